// File: rtl/rom_dl_pkg.sv
// Shared types and helpers for the ROM download router.
// FIFO entry layout, download FSM states and a byte-wise reflected CRC-32 step.
package rom_dl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAIN,
      DONE
   } dl_state_t;

   typedef struct packed {
      logic [16:0] addr;
      logic [7:0]  data;
   } dl_entry_t;

   localparam logic [31:0] CRC32_POLY = 32'hEDB88320;

   // Advance a reflected CRC-32 register by one byte, LSB first.
   function automatic logic [31:0] crc8_step(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h000000, data};
      for (int unsigned i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/dl_fifo.sv
// Synchronous FIFO of dl_entry_t used to decouple hps_io writes from core writes.
// DEPTH must be a power of two so the pointers wrap naturally.
module dl_fifo
   import rom_dl_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  dl_entry_t                din,
   input  logic                     pop,
   output dl_entry_t                dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   dl_entry_t       mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   // Pointer and occupancy bookkeeping; flush discards everything queued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage array; not reset, contents are only meaningful below count.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/rom_dl_router.sv
// ROM download router: buffers hps_io ioctl bytes and replays them to the core
// load port when the core is ready, holding the core in reset while loading.
// Optional feature macro: ROM_DL_CRC_EN (CRC-32 check of delivered bytes;
// EXPECT_CRC exists only in that build).
module rom_dl_router
   import rom_dl_pkg::*;
#(
   parameter logic [7:0]  ROM_INDEX  = 8'd0,
   parameter logic [16:0] ROM_SIZE   = 17'h1C000,
   parameter int unsigned FIFO_DEPTH = 4
`ifdef ROM_DL_CRC_EN
   ,
   parameter logic [31:0] EXPECT_CRC = 32'h0
`endif
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic [16:0] dn_addr,
   output logic [7:0]  dn_data,
   output logic        dn_wr,
   input  logic        dn_ready,
   output logic        hold_reset,
   output logic        dl_done,
   output logic        dl_err,
   output logic [16:0] byte_count,
   output logic        crc_ok
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   dl_state_t  state;
   dl_state_t  state_nxt;
   logic       dl_q;
   logic       dl_rise;
   logic       start;
   logic       flush;
   logic       in_range;
   logic       push;
   logic       pop;
   logic       drop;
   logic       fifo_full;
   logic       fifo_empty;
   logic [CW-1:0] fifo_count;
   dl_entry_t  fifo_din;
   dl_entry_t  fifo_dout;

   // Delayed copy of ioctl_download for edge detection.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) dl_q <= 1'b0;
      else          dl_q <= ioctl_download;
   end

   assign dl_rise = ioctl_download & ~dl_q & (ioctl_index == ROM_INDEX);

   // Download state register.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic; start marks entry into LOAD, flush drops a stale drain.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      flush     = 1'b0;
      case (state)
         IDLE: begin
            if (dl_rise) begin
               state_nxt = LOAD;
               start     = 1'b1;
            end
         end
         LOAD: begin
            if (!ioctl_download) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (dl_rise) begin
               state_nxt = LOAD;
               start     = 1'b1;
               flush     = 1'b1;
            end else if (fifo_empty && !dn_wr) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (dl_rise) begin
               state_nxt = LOAD;
               start     = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A full FIFO still accepts a byte when the same cycle pops one.
   assign in_range = (ioctl_addr < {8'h00, ROM_SIZE});
   assign pop      = ~fifo_empty & dn_ready & ~flush;
   assign push     = (state == LOAD) & ioctl_wr & in_range & (~fifo_full | pop);
   assign drop     = (state == LOAD) & ioctl_wr & (~in_range | (fifo_full & ~pop));
   assign fifo_din = '{addr: ioctl_addr[16:0], data: ioctl_dout};

   dl_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_sys),
      .rst_n (reset_n),
      .flush (flush),
      .push  (push),
      .din   (fifo_din),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Core write port, byte counter and sticky error flag.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dn_wr      <= 1'b0;
         dn_addr    <= '0;
         dn_data    <= '0;
         byte_count <= '0;
         dl_err     <= 1'b0;
      end else begin
         dn_wr <= pop;
         if (pop) begin
            dn_addr <= fifo_dout.addr;
            dn_data <= fifo_dout.data;
         end
         if (start)                                   byte_count <= '0;
         else if (dn_wr && (byte_count != 17'h1FFFF)) byte_count <= byte_count + 1'b1;
         if (start)     dl_err <= 1'b0;
         else if (drop) dl_err <= 1'b1;
      end
   end

   assign ioctl_wait = (fifo_count >= CW'(FIFO_DEPTH - 1));
   assign hold_reset = (state == LOAD) || (state == DRAIN);
   assign dl_done    = (state == DONE);

`ifdef ROM_DL_CRC_EN
   logic [31:0] crc;

   // Running CRC over bytes exactly as they leave on dn_wr.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)   crc <= '1;
      else if (start) crc <= '1;
      else if (dn_wr) crc <= crc8_step(crc, dn_data);
   end

   assign crc_ok = dl_done && ((crc ^ 32'hFFFFFFFF) == EXPECT_CRC);
`else
   assign crc_ok = dl_done;
`endif

endmodule
